// File: rtl/apb_arb_pkg.sv
// Shared types and constants for the two-requester APB3 CSR arbiter.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
package apb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_e;

    localparam logic APB_OK    = 1'b0;
    localparam logic APB_ERROR = 1'b1;

    localparam int NUM_REQ = 2;

    // One-hot vector with only the bit of requester idx set.
    function automatic logic [NUM_REQ-1:0] owner_onehot(input logic idx);
        logic [NUM_REQ-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: on a tie, the port that did not win last time wins.
// Latency: purely combinational.
// Backpressure: grant_o is zero while enable_i is low.
// Ports: valid_i[1:0] requests, last_grant_i previous winner, enable_i grant enable,
//        grant_o[1:0] one-hot grant, next_last_o winner to remember if granted.
module rr_arb2 (
    input  logic [1:0] valid_i,
    input  logic       last_grant_i,
    input  logic       enable_i,
    output logic [1:0] grant_o,
    output logic       next_last_o
);

    always_comb begin
        grant_o     = 2'b00;
        next_last_o = last_grant_i;
        if (enable_i) begin
            if (valid_i == 2'b11) begin
                grant_o = last_grant_i ? 2'b01 : 2'b10;
            end else begin
                grant_o = valid_i;
            end
        end
        if (grant_o[1]) begin
            next_last_o = 1'b1;
        end else if (grant_o[0]) begin
            next_last_o = 1'b0;
        end
    end

endmodule

// File: rtl/apb_csr_arbiter.sv
// Two-requester APB3 master sharing one CSR slave, round-robin arbitration.
// Latency: 3 cycles accept->done with no wait states; +1 per wait state, abort after TIMEOUT waits.
// Backpressure: reqN_ready only in IDLE; valid may be held indefinitely while busy.
// Ports: pclk/preset_n; req0_*/req1_* command in (valid/write/addr/wdata), ready/done/rdata/err out;
//        m_psel/m_penable/m_pwrite/m_paddr/m_pwdata APB out; m_prdata/m_pready/m_pslverr APB in.
module apb_csr_arbiter
    import apb_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        pclk,
    input  logic        preset_n,

    input  logic        req0_valid,
    input  logic        req0_write,
    input  logic [31:0] req0_addr,
    input  logic [31:0] req0_wdata,
    output logic        req0_ready,
    output logic        req0_done,
    output logic [31:0] req0_rdata,
    output logic        req0_err,

    input  logic        req1_valid,
    input  logic        req1_write,
    input  logic [31:0] req1_addr,
    input  logic [31:0] req1_wdata,
    output logic        req1_ready,
    output logic        req1_done,
    output logic [31:0] req1_rdata,
    output logic        req1_err,

    output logic        m_psel,
    output logic        m_penable,
    output logic        m_pwrite,
    output logic [31:0] m_paddr,
    output logic [31:0] m_pwdata,
    input  logic [31:0] m_prdata,
    input  logic        m_pready,
    input  logic        m_pslverr
);

    localparam bit              TO_EN  = (TIMEOUT != 0);
    localparam int              CW     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0]   TO_LIM = CW'(TIMEOUT);

    state_e                     state_q, state_d;
    logic                       last_grant_q;
    logic                       owner_q;
    logic                       psel_q, penable_q, pwrite_q;
    logic [31:0]                paddr_q, pwdata_q;
    logic [CW-1:0]              wait_cnt_q;
    logic [NUM_REQ-1:0]         done_q;
    logic [NUM_REQ-1:0]         err_q;
    logic [NUM_REQ-1:0][31:0]   rdata_q;

    logic [1:0]                 grant;
    logic                       next_last;
    logic                       accept;
    logic                       xfer_ok;
    logic                       timed_out;
    logic                       complete;

    rr_arb2 u_rr_arb2 (
        .valid_i      ({req1_valid, req0_valid}),
        .last_grant_i (last_grant_q),
        .enable_i     (state_q == IDLE),
        .grant_o      (grant),
        .next_last_o  (next_last)
    );

    assign accept = |grant;

    // A slave response in the same cycle as the limit is honoured rather than aborted.
    assign xfer_ok   = (state_q == ACCESS) && m_pready;
    assign timed_out = TO_EN && (state_q == ACCESS) && !m_pready && (wait_cnt_q == TO_LIM);
    assign complete  = xfer_ok || timed_out;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)   state_d = SETUP;
            SETUP:                 state_d = ACCESS;
            ACCESS:  if (complete) state_d = IDLE;
            default:               state_d = IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            psel_q       <= 1'b0;
            penable_q    <= 1'b0;
            pwrite_q     <= 1'b0;
            paddr_q      <= '0;
            pwdata_q     <= '0;
            wait_cnt_q   <= '0;
            done_q       <= '0;
            err_q        <= {NUM_REQ{APB_OK}};
            rdata_q      <= '0;
        end else begin
            done_q <= '0;

            if (accept) begin
                owner_q      <= grant[1];
                last_grant_q <= next_last;
                paddr_q      <= grant[1] ? req1_addr  : req0_addr;
                pwdata_q     <= grant[1] ? req1_wdata : req0_wdata;
                pwrite_q     <= grant[1] ? req1_write : req0_write;
                psel_q       <= 1'b1;
            end

            if (state_q == SETUP) begin
                penable_q  <= 1'b1;
                wait_cnt_q <= '0;
            end

            if (state_q == ACCESS) begin
                if (complete) begin
                    psel_q    <= 1'b0;
                    penable_q <= 1'b0;
                end else if (TO_EN) begin
                    wait_cnt_q <= wait_cnt_q + CW'(1);
                end
            end

            // Only the owner's response registers move; an abort reports error with zero data.
            if (complete) begin
                done_q           <= owner_onehot(owner_q);
                err_q[owner_q]   <= xfer_ok ? m_pslverr : APB_ERROR;
                rdata_q[owner_q] <= (xfer_ok && !pwrite_q) ? m_prdata : 32'h0;
            end
        end
    end

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];
    assign req0_done  = done_q[0];
    assign req1_done  = done_q[1];
    assign req0_rdata = rdata_q[0];
    assign req1_rdata = rdata_q[1];
    assign req0_err   = err_q[0];
    assign req1_err   = err_q[1];

    assign m_psel    = psel_q;
    assign m_penable = penable_q;
    assign m_pwrite  = pwrite_q;
    assign m_paddr   = paddr_q;
    assign m_pwdata  = pwdata_q;

endmodule

// File: tb/tb_apb_csr_arbiter.sv
module tb_apb_csr_arbiter;

    logic        pclk = 1'b0;
    logic        preset_n;
    logic        req0_valid, req0_write, req0_ready, req0_done, req0_err;
    logic [31:0] req0_addr, req0_wdata, req0_rdata;
    logic        req1_valid, req1_write, req1_ready, req1_done, req1_err;
    logic [31:0] req1_addr, req1_wdata, req1_rdata;
    logic        m_psel, m_penable, m_pwrite, m_pready, m_pslverr;
    logic [31:0] m_paddr, m_pwdata, m_prdata;

    int checks = 0;
    int errors = 0;

    always #5 pclk = ~pclk;

    apb_csr_arbiter #(.TIMEOUT(16)) dut (
        .pclk       (pclk),
        .preset_n   (preset_n),
        .req0_valid (req0_valid),
        .req0_write (req0_write),
        .req0_addr  (req0_addr),
        .req0_wdata (req0_wdata),
        .req0_ready (req0_ready),
        .req0_done  (req0_done),
        .req0_rdata (req0_rdata),
        .req0_err   (req0_err),
        .req1_valid (req1_valid),
        .req1_write (req1_write),
        .req1_addr  (req1_addr),
        .req1_wdata (req1_wdata),
        .req1_ready (req1_ready),
        .req1_done  (req1_done),
        .req1_rdata (req1_rdata),
        .req1_err   (req1_err),
        .m_psel     (m_psel),
        .m_penable  (m_penable),
        .m_pwrite   (m_pwrite),
        .m_paddr    (m_paddr),
        .m_pwdata   (m_pwdata),
        .m_prdata   (m_prdata),
        .m_pready   (m_pready),
        .m_pslverr  (m_pslverr)
    );

    // Advance to 1 time unit after the next rising edge; inputs are driven there.
    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    // Let combinational ready settle after driving inputs.
    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        req0_valid = 1'b0; req0_write = 1'b0; req0_addr = '0; req0_wdata = '0;
        req1_valid = 1'b0; req1_write = 1'b0; req1_addr = '0; req1_wdata = '0;
        m_pready   = 1'b1; m_pslverr  = 1'b0; m_prdata  = '0;
    endtask

    task automatic test_reset();
        preset_n = 1'b0;
        idle_inputs();
        step();
        step();
        checks++; if (m_psel !== 1'b0)     begin errors++; $display("FAIL reset_psel got %0b want 0", m_psel); end
        checks++; if (m_penable !== 1'b0)  begin errors++; $display("FAIL reset_penable got %0b want 0", m_penable); end
        checks++; if (m_pwrite !== 1'b0)   begin errors++; $display("FAIL reset_pwrite got %0b want 0", m_pwrite); end
        checks++; if (m_paddr !== 32'h0)   begin errors++; $display("FAIL reset_paddr got %h want 0", m_paddr); end
        checks++; if (m_pwdata !== 32'h0)  begin errors++; $display("FAIL reset_pwdata got %h want 0", m_pwdata); end
        checks++; if ({req1_done, req0_done} !== 2'b00) begin errors++; $display("FAIL reset_done got %b want 00", {req1_done, req0_done}); end
        checks++; if ({req1_err, req0_err} !== 2'b00)   begin errors++; $display("FAIL reset_err got %b want 00", {req1_err, req0_err}); end
        checks++; if (req0_rdata !== 32'h0 || req1_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h/%h want 0/0", req0_rdata, req1_rdata); end
        preset_n = 1'b1;
        step();
    endtask

    task automatic test_write_p0();
        req0_valid = 1'b1; req0_write = 1'b1; req0_addr = 32'h4; req0_wdata = 32'h0000_00AA;
        m_pready = 1'b1;
        settle();
        checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL wr0_ready got %0b want 1", req0_ready); end
        step();                                   // cycle 1: SETUP
        req0_valid = 1'b0;
        checks++; if ({m_psel, m_penable} !== 2'b10) begin errors++; $display("FAIL wr0_setup psel/penable got %b want 10", {m_psel, m_penable}); end
        checks++; if (m_paddr !== 32'h4 || m_pwdata !== 32'hAA || m_pwrite !== 1'b1) begin
            errors++; $display("FAIL wr0_cmd got addr %h wdata %h wr %0b want 4 aa 1", m_paddr, m_pwdata, m_pwrite);
        end
        checks++; if (req0_done !== 1'b0) begin errors++; $display("FAIL wr0_early_done_c1 got %0b want 0", req0_done); end
        step();                                   // cycle 2: ACCESS
        checks++; if ({m_psel, m_penable} !== 2'b11) begin errors++; $display("FAIL wr0_access psel/penable got %b want 11", {m_psel, m_penable}); end
        checks++; if (req0_done !== 1'b0) begin errors++; $display("FAIL wr0_early_done_c2 got %0b want 0", req0_done); end
        step();                                   // cycle 3: done
        checks++; if (req0_done !== 1'b1 || req0_err !== 1'b0) begin errors++; $display("FAIL wr0_done done/err got %0b/%0b want 1/0", req0_done, req0_err); end
        checks++; if (req1_done !== 1'b0) begin errors++; $display("FAIL wr0_other_done got %0b want 0", req1_done); end
        checks++; if ({m_psel, m_penable} !== 2'b00) begin errors++; $display("FAIL wr0_idle psel/penable got %b want 00", {m_psel, m_penable}); end
        step();
        checks++; if (req0_done !== 1'b0) begin errors++; $display("FAIL wr0_done_pulse got %0b want 0", req0_done); end
    endtask

    task automatic test_read_p1();
        req1_valid = 1'b1; req1_write = 1'b0; req1_addr = 32'h4;
        m_pready = 1'b1; m_prdata = 32'h0000_00AA;
        settle();
        checks++; if ({req1_ready, req0_ready} !== 2'b10) begin errors++; $display("FAIL rd1_ready got %b want 10", {req1_ready, req0_ready}); end
        step();
        req1_valid = 1'b0;
        checks++; if (m_pwrite !== 1'b0 || m_paddr !== 32'h4) begin errors++; $display("FAIL rd1_cmd got wr %0b addr %h want 0 4", m_pwrite, m_paddr); end
        step();
        step();
        checks++; if (req1_done !== 1'b1) begin errors++; $display("FAIL rd1_done got %0b want 1", req1_done); end
        checks++; if (req1_rdata !== 32'h0000_00AA) begin errors++; $display("FAIL rd1_rdata got %h want 000000aa", req1_rdata); end
        checks++; if (req1_err !== 1'b0) begin errors++; $display("FAIL rd1_err got %0b want 0", req1_err); end
        checks++; if (req0_done !== 1'b0) begin errors++; $display("FAIL rd1_other_done got %0b want 0", req0_done); end
        m_prdata = '0;
        step();
    endtask

    task automatic test_back_to_back();
        int i0, i1, n_acc, n_done, cyc, last_done;
        int gseq [6];
        int dseq [6];
        int acc_cyc [6];
        for (int k = 0; k < 6; k++) begin
            gseq[k] = -1; dseq[k] = -1; acc_cyc[k] = -1;
        end
        preset_n = 1'b0;
        idle_inputs();
        step();
        preset_n = 1'b1;
        i0 = 0; i1 = 0; n_acc = 0; n_done = 0; cyc = 0; last_done = -1;
        m_prdata = 32'h5A;
        req0_valid = 1'b1; req0_write = 1'b1; req0_addr = 32'h10; req0_wdata = 32'h100;
        req1_valid = 1'b1; req1_write = 1'b0; req1_addr = 32'h20;
        while (n_done < 6 && cyc < 60) begin
            settle();
            if (req0_ready) begin
                if (n_acc < 6) begin gseq[n_acc] = 0; acc_cyc[n_acc] = cyc; end
                n_acc++; i0++;
            end else if (req1_ready) begin
                if (n_acc < 6) begin gseq[n_acc] = 1; acc_cyc[n_acc] = cyc; end
                n_acc++; i1++;
            end
            if (req0_done) begin
                if (n_done < 6) dseq[n_done] = 0;
                n_done++; last_done = cyc;
            end
            if (req1_done) begin
                if (n_done < 6) dseq[n_done] = 1;
                n_done++; last_done = cyc;
            end
            step();
            req0_valid = (i0 < 3); req0_addr = 32'h10 + 32'(4 * i0); req0_wdata = 32'h100 + 32'(i0);
            req1_valid = (i1 < 3); req1_addr = 32'h20 + 32'(4 * i1);
            cyc++;
        end
        checks++; if (n_done != 6) begin errors++; $display("FAIL b2b_done_count got %0d want 6", n_done); end
        for (int k = 0; k < 6; k++) begin
            checks++; if (gseq[k] != k % 2) begin errors++; $display("FAIL b2b_grant[%0d] got %0d want %0d", k, gseq[k], k % 2); end
            checks++; if (acc_cyc[k] != 3 * k) begin errors++; $display("FAIL b2b_accept_cycle[%0d] got %0d want %0d", k, acc_cyc[k], 3 * k); end
            checks++; if (dseq[k] != k % 2) begin errors++; $display("FAIL b2b_done_owner[%0d] got %0d want %0d", k, dseq[k], k % 2); end
        end
        checks++; if (last_done != 18) begin errors++; $display("FAIL b2b_total_cycles got %0d want 18", last_done); end
        idle_inputs();
    endtask

    task automatic test_wait_err();
        req0_valid = 1'b1; req0_write = 1'b0; req0_addr = 32'h8;
        m_pready = 1'b0; m_pslverr = 1'b0; m_prdata = '0;
        settle();
        checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL wait_ready got %0b want 1", req0_ready); end
        step();
        req0_valid = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            m_pready  = (c >= 7);
            m_pslverr = (c == 7);
            m_prdata  = (c == 7) ? 32'h1234 : 32'h0;
            settle();
            checks++; if (req0_done !== (c == 8)) begin errors++; $display("FAIL wait_done_c%0d got %0b want %0b", c, req0_done, (c == 8)); end
            if (c == 6) begin
                checks++; if ({m_psel, m_penable} !== 2'b11) begin errors++; $display("FAIL wait_hold_access got %b want 11", {m_psel, m_penable}); end
            end
            if (c == 8) begin
                checks++; if (req0_err !== 1'b1) begin errors++; $display("FAIL wait_err got %0b want 1", req0_err); end
                checks++; if (req0_rdata !== 32'h1234) begin errors++; $display("FAIL wait_rdata got %h want 00001234", req0_rdata); end
            end
            step();
        end
        idle_inputs();
    endtask

    task automatic test_timeout();
        req1_valid = 1'b1; req1_write = 1'b0; req1_addr = 32'hC;
        m_pready = 1'b0; m_prdata = 32'hDEAD_BEEF;
        settle();
        checks++; if (req1_ready !== 1'b1) begin errors++; $display("FAIL to_ready got %0b want 1", req1_ready); end
        step();
        req1_valid = 1'b0;
        for (int c = 1; c <= 24; c++) begin
            m_pready = (c >= 21);             // late response after the abort
            settle();
            checks++; if (req1_done !== (c == 19)) begin errors++; $display("FAIL to_done_c%0d got %0b want %0b", c, req1_done, (c == 19)); end
            if (c == 19) begin
                checks++; if (req1_err !== 1'b1) begin errors++; $display("FAIL to_err got %0b want 1", req1_err); end
                checks++; if (req1_rdata !== 32'h0) begin errors++; $display("FAIL to_rdata got %h want 0", req1_rdata); end
                checks++; if ({m_psel, m_penable} !== 2'b00) begin errors++; $display("FAIL to_idle got %b want 00", {m_psel, m_penable}); end
            end
            step();
        end
        m_pready = 1'b1;
        req0_valid = 1'b1; req0_write = 1'b1; req0_addr = 32'h40; req0_wdata = 32'h55;
        settle();
        checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL to_next_ready got %0b want 1", req0_ready); end
        step();
        req0_valid = 1'b0;
        step();
        step();
        checks++; if (req0_done !== 1'b1 || req0_err !== 1'b0) begin errors++; $display("FAIL to_next_done done/err got %0b/%0b want 1/0", req0_done, req0_err); end
        idle_inputs();
        step();
    endtask

    task automatic test_reset_mid();
        req0_valid = 1'b1; req0_write = 1'b1; req0_addr = 32'h30; req0_wdata = 32'h33;
        m_pready = 1'b0;
        settle();
        checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready got %0b want 1", req0_ready); end
        step();
        req0_valid = 1'b0;
        step();
        step();
        checks++; if (m_penable !== 1'b1) begin errors++; $display("FAIL rst_mid_in_access got %0b want 1", m_penable); end
        preset_n = 1'b0;
        #1;
        checks++; if ({m_psel, m_penable} !== 2'b00) begin errors++; $display("FAIL rst_mid_apb got %b want 00", {m_psel, m_penable}); end
        checks++; if (m_paddr !== 32'h0) begin errors++; $display("FAIL rst_mid_paddr got %h want 0", m_paddr); end
        m_pready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            checks++; if ({req1_done, req0_done} !== 2'b00) begin errors++; $display("FAIL rst_mid_no_done_%0d got %b want 00", c, {req1_done, req0_done}); end
        end
        preset_n = 1'b1;
        req0_valid = 1'b1; req0_write = 1'b0; req0_addr = 32'h50;
        req1_valid = 1'b1; req1_write = 1'b0; req1_addr = 32'h60;
        settle();
        checks++; if ({req1_ready, req0_ready} !== 2'b01) begin errors++; $display("FAIL rst_mid_first_grant got %b want 01", {req1_ready, req0_ready}); end
        step();
        idle_inputs();
        repeat (4) step();
    endtask

    initial begin
        test_reset();
        test_write_p0();
        test_read_p1();
        test_back_to_back();
        test_wait_err();
        test_timeout();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/apb_csr_arbiter.md
# apb_csr_arbiter

Two-requester APB3 master that shares one APB3 CSR slave (e.g. the threshold/empty-state register block) between a host-side requester (port 0) and an on-chip configuration/monitor engine (port 1). It accepts one command at a time from each requester through a valid/ready handshake and runs the APB3 SETUP/ACCESS sequence on the shared bus. It returns read data and error status per requester. Arbitration is round-robin, and a wait-state timeout bounds any transfer.

## Interface
- TIMEOUT, 16: maximum ACCESS cycles with m_pready low before abort; 0 disables the timeout.
- pclk  in  1  clock
- preset_n  in  1  asynchronous, active-low reset
- reqN_valid  in  1  command valid, N=0,1; held until reqN_ready
- reqN_write  in  1  1=write, 0=read
- reqN_addr  in  32  byte address
- reqN_wdata  in  32  write data
- reqN_ready  out  1  command accepted this cycle (combinational)
- reqN_done  out  1  one-cycle completion pulse (registered)
- reqN_rdata  out  32  read data, valid while reqN_done=1
- reqN_err  out  1  slave error or timeout, valid while reqN_done=1
- m_psel, m_penable, m_pwrite  out  1  APB3 master controls
- m_paddr, m_pwdata  out  32  APB3 address/write data
- m_prdata  in  32  APB3 read data
- m_pready, m_pslverr  in  1  APB3 response

## Operation
- FSM states and transitions:
  - IDLE -> SETUP when either valid is high; the winner's ready=1 that cycle.
  - SETUP -> ACCESS unconditionally.
  - ACCESS -> IDLE on m_pready=1 or timeout.
- Arbitration register last_grant, reset value 1, so port 0 wins the first tie.
  - If both requesters are valid, the port not equal to last_grant wins.
  - If only one is valid, that port wins.
  - last_grant updates only on accept.
- Command capture on accept: addr, wdata, write and the grant index are latched into m_paddr, m_pwdata, m_pwrite and the owner register.
  - m_paddr and m_pwdata hold their value until the next accept.
- Completion:
  - reqN_done pulses for the owner only; the other port's done stays 0.
  - rdata = m_prdata for reads and 0 for writes.
  - err = m_pslverr.
- Timeout:
  - A wait counter clears on entry to ACCESS and increments on each ACCESS cycle with m_pready=0.
  - If the counter reaches TIMEOUT, the FSM leaves ACCESS, the owner gets done=1, err=1, rdata=0.
  - A late m_pready after abort is ignored.
- Requesters never receive ready while the FSM is not in IDLE; valid may be held indefinitely.
- Reset (asynchronous, any time, including mid-transfer):
  - FSM goes to IDLE; last_grant=1; wait counter=0.
  - All outputs go to 0 (m_psel, m_penable, m_pwrite, m_paddr, m_pwdata, reqN_done, reqN_rdata, reqN_err).
  - No done is issued for an in-flight transfer.

## Timing
- Cycle 0 (IDLE): valid sampled, ready=1 combinationally, command latched at the clock edge.
- Cycle 1 (SETUP): m_psel=1, m_penable=0.
- Cycle 2 (ACCESS): m_psel=1, m_penable=1; repeats while m_pready=0.
- Cycle after the completing ACCESS: FSM is in IDLE, reqN_done=1, m_psel=m_penable=0.
  - A new command may be accepted in this same cycle.
- Zero-wait latency is 3 cycles from accept to done; throughput is one transfer per 3 cycles.
- A timeout abort adds TIMEOUT cycles; done then appears TIMEOUT+3 cycles after accept.
- All APB outputs and done/rdata/err are registered; only reqN_ready is combinational from valid and state.

## Structure
- Package apb_arb_pkg:
  - state encoding IDLE=2'd0, SETUP=2'd1, ACCESS=2'd2;
  - APB_OK=1'b0, APB_ERROR=1'b1;
  - NUM_REQ=2.
- Sub-module rr_arb2 contains the 2-way round-robin grant logic: inputs valid[1:0], last_grant, enable; outputs grant[1:0], next_last.
- Top level contains the FSM, the command/owner registers, the timeout counter and response routing.
- Expected RTL size is about 200 lines.

## Test plan
- Port 0 writes 0x0000_00AA to 0x4 with m_pready tied 1:
  - m_psel rises 1 cycle after accept and m_penable 2 cycles after;
  - req0_done rises 3 cycles after accept with err=0;
  - req1_done stays 0.
- Port 1 reads 0x4 with slave returning 0x0000_00AA and m_pready tied 1 -> req1_done with req1_rdata=0x0000_00AA, err=0.
- Both valid from reset, each issuing 3 commands back-to-back -> grants alternate 0,1,0,1,0,1; the transfers occupy 18 cycles in total.
- m_pready held low 5 ACCESS cycles then high, with m_pslverr=1 -> done 8 cycles after accept with err=1.
- m_pready held low forever with TIMEOUT=16 -> done 19 cycles after accept with err=1, rdata=0; the FSM returns to IDLE and accepts the next command.
- Assert preset_n low during ACCESS -> m_psel=m_penable=0 immediately, no done pulse; the first command after reset is granted to port 0 when both ports are valid.
